// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit; Prescale CLK cycles per bit.
// Build option UART_TX_TWO_STOP_EN stretches the stop bit to two bit periods.
module uart_tx_frame #(
    parameter int unsigned Data_Width = 8,
    parameter int unsigned C_W        = $clog2(Data_Width)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    input  logic                  Data_Valid,
    input  logic [Data_Width-1:0] P_DATA,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam logic [C_W-1:0] LAST_IDX = C_W'(Data_Width - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [5:0]            cnt;
    logic [5:0]            presc_q;
    logic [C_W-1:0]        bit_idx;
    logic [Data_Width-1:0] shift_reg;
    logic [Data_Width-1:0] shift_nxt;
    logic                  par_en_q;
    logic                  parity_q;
    logic                  bit_end;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop_second;
`endif

    // Bit period ends on the last count of the latched (zero-corrected) prescale.
    assign bit_end   = (cnt == presc_q - 6'd1);
    assign shift_nxt = shift_reg >> 1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            presc_q     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            par_en_q    <= 1'b0;
            parity_q    <= 1'b0;
            TX_OUT      <= 1'b1;
            Busy        <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_second <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Data_Valid) begin
                        shift_reg <= P_DATA;
                        par_en_q  <= PAR_EN;
                        parity_q  <= (^P_DATA) ^ PAR_TYP;
                        presc_q   <= (Prescale == 6'd0) ? 6'd1 : Prescale;
                        cnt       <= '0;
                        bit_idx   <= '0;
                        state     <= START;
                        TX_OUT    <= 1'b0;
                        Busy      <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt    <= '0;
                        state  <= DATA;
                        TX_OUT <= shift_reg[0];
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        shift_reg <= shift_nxt;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            if (par_en_q) begin
                                state  <= PARITY;
                                TX_OUT <= parity_q;
                            end else begin
                                state  <= STOP;
                                TX_OUT <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + C_W'(1);
                            TX_OUT  <= shift_nxt[0];
                        end
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt    <= '0;
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
`ifdef UART_TX_TWO_STOP_EN
                        if (!stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            stop_second <= 1'b0;
                            state       <= IDLE;
                            Busy        <= 1'b0;
                        end
`else
                        state <= IDLE;
                        Busy  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomised self-checking bench for uart_tx_frame against a per-cycle frame model.
// Honours UART_TX_TWO_STOP_EN the same way as the design.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd0;
    logic       Data_Valid = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       TX_OUT;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    uart_tx_frame #(.Data_Width(8)) dut (
        .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .Prescale(Prescale), .Data_Valid(Data_Valid), .P_DATA(P_DATA),
        .TX_OUT(TX_OUT), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    typedef struct packed { logic tx; logic busy; } ob_t;
    ob_t  q[$];
    logic trace[$];
    int   e[$];
    logic rec_en = 1'b0;
    logic exp_tx, exp_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line/busy for every cycle of a frame, followed by the mandatory idle cycle.
    function automatic void build_frame(input logic [7:0] d, input logic pe, input logic pt,
                                        input logic [5:0] ps);
        logic bits[$];
        int   p;
        p = (ps == 6'd0) ? 1 : int'(ps);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ pt);
        for (int i = 0; i < STOP_BITS; i++) bits.push_back(1'b1);
        foreach (bits[b])
            for (int k = 0; k < p; k++) q.push_back('{tx: bits[b], busy: 1'b1});
        q.push_back('{tx: 1'b1, busy: 1'b0});
    endfunction

    // Model step then compare, every cycle.
    always @(posedge CLK) begin
        ob_t ob;
        if (RST) begin
            q.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end else begin
            if (q.size() == 0 && Data_Valid) build_frame(P_DATA, PAR_EN, PAR_TYP, Prescale);
            if (q.size() > 0) begin
                ob       = q.pop_front();
                exp_tx   = ob.tx;
                exp_busy = ob.busy;
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
        end
        #1;
        check("cyc_tx", 32'(TX_OUT), 32'(exp_tx));
        check("cyc_busy", 32'(Busy), 32'(exp_busy));
        if (rec_en && Busy) trace.push_back(TX_OUT);
    end

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        @(negedge CLK);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for idle, got %0d cycles required <3000", name, n);
        end
    endtask

    // Compare recorded busy-cycle line samples against the literal bit list in e.
    task automatic check_trace(input string name, input int p, input int len);
        check({name, "_len"}, 32'(trace.size()), 32'(len));
        if (trace.size() == len)
            foreach (e[b]) check({name, "_bit"}, 32'(trace[b * p + p / 2]), 32'(e[b]));
    endtask

    task automatic frame_a5;
        trace.delete();
        rec_en = 1'b1;
        send(8'hA5, 1'b1, 1'b0, 6'd8);
        wait_idle("a5");
        rec_en = 1'b0;
        e = '{0, 1,0,1,0,0,1,0,1, 0, 1};
        if (STOP_BITS == 2) e.push_back(1);
        check_trace("a5", 8, (STOP_BITS == 2) ? 96 : 88);
        if (trace.size() >= 16)
            for (int i = trace.size() - 16; i < trace.size(); i++)
                if (STOP_BITS == 2) check("a5_tail_high", 32'(trace[i]), 32'd1);
    endtask

    initial begin
        int len;
        // Reset and idle.
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        check("idle_tx", 32'(TX_OUT), 32'd1);
        check("idle_busy", 32'(Busy), 32'd0);

        frame_a5();

        // No parity, odd type ignored.
        trace.delete();
        rec_en = 1'b1;
        send(8'h3C, 1'b0, 1'b1, 6'd4);
        wait_idle("3c");
        rec_en = 1'b0;
        e = '{0, 0,0,1,1,1,1,0,0, 1};
        if (STOP_BITS == 2) e.push_back(1);
        check_trace("3c", 4, (STOP_BITS == 2) ? 44 : 40);

        // Prescale 0 acts as 1, odd parity.
        trace.delete();
        rec_en = 1'b1;
        send(8'h01, 1'b1, 1'b1, 6'd0);
        wait_idle("01");
        rec_en = 1'b0;
        e = '{0, 1,0,0,0,0,0,0,0, 0, 1};
        if (STOP_BITS == 2) e.push_back(1);
        check_trace("01", 1, (STOP_BITS == 2) ? 12 : 11);

        // Data_Valid held across STOP->IDLE: exactly one idle cycle between frames.
        len = (STOP_BITS == 2) ? 12 : 11;
        @(negedge CLK);
        P_DATA = 8'h01; PAR_EN = 1'b1; PAR_TYP = 1'b1; Prescale = 6'd0; Data_Valid = 1'b1;
        for (int i = 0; i <= len + 1; i++) begin
            @(negedge CLK);
            check("held_busy", 32'(Busy), (i == len) ? 32'd0 : 32'd1);
        end
        Data_Valid = 1'b0;
        wait_idle("held");

        // Mid-frame request and config changes are ignored.
        trace.delete();
        rec_en = 1'b1;
        send(8'h55, 1'b1, 1'b0, 6'd4);
        repeat (10) @(negedge CLK);
        P_DATA = 8'hFF; PAR_TYP = 1'b1; Prescale = 6'd2; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        wait_idle("55");
        rec_en = 1'b0;
        e = '{0, 1,0,1,0,1,0,1,0, 0, 1};
        if (STOP_BITS == 2) e.push_back(1);
        check_trace("55", 4, (STOP_BITS == 2) ? 48 : 44);

        // Asynchronous reset mid-DATA.
        send(8'h55, 1'b1, 1'b0, 6'd4);
        repeat (8) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst_tx", 32'(TX_OUT), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        frame_a5();

        // Randomised frames with occasional ignored mid-frame requests.
        for (int n = 0; n < 40; n++) begin
            send(8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(0, 6)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 8)) @(negedge CLK);
                P_DATA = 8'($urandom); PAR_TYP = 1'($urandom);
                Prescale = 6'($urandom_range(0, 6)); Data_Valid = 1'b1;
                @(negedge CLK);
                Data_Valid = 1'b0;
            end
            wait_idle("rand");
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
